// File: rtl/sound_sequencer.sv
// Sequences short tone patterns (coin chirp, vend chime, error beeps) onto a tone generator.
// Requests are queued in per-source pending flags; an error request preempts a coin or vend pattern.
module sound_sequencer #(
    parameter int unsigned CLOCK_HZ     = 100_000_000,
    parameter int unsigned TONE_MS      = 150,
    parameter int unsigned GAP_MS       = 50,
    parameter int unsigned ERROR_REPEAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_req,
    input  logic       vend_req,
    input  logic [1:0] vend_item,
    input  logic       error_req,
    output logic       tone_start,
    output logic       tone_error,
    output logic [1:0] tone_item,
    output logic       busy
);

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned NOTES_W     = 3;
    localparam int unsigned NOTE_CYCLES = (CLOCK_HZ / 1000) * TONE_MS;
    localparam int unsigned GAP_CYCLES  = (CLOCK_HZ / 1000) * GAP_MS;

    typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;
    typedef enum logic [1:0] {PAT_COIN, PAT_VEND, PAT_ERR} pat_t;

    state_t             state, state_d;
    pat_t               pat, pat_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [NOTES_W-1:0] notes, notes_d;
    logic [1:0]         item_d, pend_item, pend_d;
    logic               err_flag, vend_flag, coin_flag;
    logic               err_d, vend_d, coin_d;
    logic               note_done, slot_done, preempt;
    logic               tone_start_d, tone_error_d, busy_d;

    // State and datapath registers; outputs are registered from next-state values
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pat        <= PAT_COIN;
            cnt        <= '0;
            notes      <= '0;
            pend_item  <= '0;
            err_flag   <= 1'b0;
            vend_flag  <= 1'b0;
            coin_flag  <= 1'b0;
            tone_start <= 1'b0;
            tone_error <= 1'b0;
            tone_item  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            pat        <= pat_d;
            cnt        <= cnt_d;
            notes      <= notes_d;
            pend_item  <= pend_d;
            err_flag   <= err_d;
            vend_flag  <= vend_d;
            coin_flag  <= coin_d;
            tone_start <= tone_start_d;
            tone_error <= tone_error_d;
            tone_item  <= item_d;
            busy       <= busy_d;
        end
    end

    // Next-state: grant, slot timing, note sequencing and error preemption
    always_comb begin
        state_d   = state;
        pat_d     = pat;
        cnt_d     = cnt;
        notes_d   = notes;
        item_d    = tone_item;
        err_d     = err_flag | error_req;
        vend_d    = vend_flag | vend_req;
        coin_d    = coin_flag | coin_req;
        pend_d    = vend_req ? vend_item : pend_item;
        note_done = 1'b0;
        slot_done = 1'b0;
        preempt   = (state != IDLE) && (pat != PAT_ERR) && error_req;

        case (state)
            IDLE: begin
                if (err_flag) begin
                    state_d = START;
                    pat_d   = PAT_ERR;
                    notes_d = NOTES_W'(ERROR_REPEAT);
                    item_d  = 2'd0;
                    err_d   = error_req;
                end else if (vend_flag) begin
                    state_d = START;
                    pat_d   = PAT_VEND;
                    notes_d = NOTES_W'(2);
                    item_d  = pend_item;
                    vend_d  = vend_req;
                end else if (coin_flag) begin
                    state_d = START;
                    pat_d   = PAT_COIN;
                    notes_d = NOTES_W'(1);
                    item_d  = 2'd0;
                    coin_d  = coin_req;
                end
            end
            START: begin
                if (NOTE_CYCLES == 1) begin
                    note_done = 1'b1;
                end else begin
                    state_d = PLAY;
                    cnt_d   = CNT_W'(NOTE_CYCLES - 2);
                end
            end
            PLAY: begin
                if (cnt == '0) note_done = 1'b1;
                else           cnt_d = cnt - CNT_W'(1);
            end
            GAP: begin
                if (cnt == '0) slot_done = 1'b1;
                else           cnt_d = cnt - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (note_done) begin
            if (GAP_CYCLES == 0) begin
                slot_done = 1'b1;
            end else begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
        end

        if (slot_done) begin
            if (notes > NOTES_W'(1)) begin
                state_d = START;
                notes_d = notes - NOTES_W'(1);
                if (pat == PAT_VEND) item_d = 2'd3;
            end else begin
                state_d = IDLE;
            end
        end

        // The aborted coin/vend pattern is dropped, not re-queued
        if (preempt) begin
            state_d = START;
            pat_d   = PAT_ERR;
            notes_d = NOTES_W'(ERROR_REPEAT);
            item_d  = 2'd0;
            err_d   = err_flag;
        end
    end

    // Output decode from the next state so pulses line up with entry into START
    always_comb begin
        tone_start_d = 1'b0;
        tone_error_d = 1'b0;
        busy_d       = (state_d != IDLE);
        if (state_d == START) begin
            if (pat_d == PAT_ERR) tone_error_d = 1'b1;
            else                  tone_start_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: expected notes are queued at stimulus time and
// popped by a monitor when the DUT pulses a tone.
module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_req, vend_req, error_req;
    logic [1:0] vend_item;
    logic       tone_start, tone_error, busy;
    logic [1:0] tone_item;

    logic       g_coin_req, g_vend_req, g_error_req;
    logic [1:0] g_vend_item;
    logic       g_tone_start, g_tone_error, g_busy;
    logic [1:0] g_tone_item;

    typedef struct {
        int cyc;
        int kind;
        int item;
    } note_t;

    note_t exp_q[$];
    int    gap0_q[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    errors   = 0;
    int    busy_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sound_sequencer #(
        .CLOCK_HZ(1000), .TONE_MS(4), .GAP_MS(2), .ERROR_REPEAT(2)
    ) u_dut (
        .clk(clk), .rst(rst), .coin_req(coin_req), .vend_req(vend_req),
        .vend_item(vend_item), .error_req(error_req), .tone_start(tone_start),
        .tone_error(tone_error), .tone_item(tone_item), .busy(busy)
    );

    sound_sequencer #(
        .CLOCK_HZ(1000), .TONE_MS(4), .GAP_MS(0), .ERROR_REPEAT(2)
    ) u_gap0 (
        .clk(clk), .rst(rst), .coin_req(g_coin_req), .vend_req(g_vend_req),
        .vend_item(g_vend_item), .error_req(g_error_req), .tone_start(g_tone_start),
        .tone_error(g_tone_error), .tone_item(g_tone_item), .busy(g_busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_note(input int c, input int kind, input int item);
        note_t n;
        n.cyc  = c;
        n.kind = kind;
        n.item = item;
        exp_q.push_back(n);
    endtask

    // kind: 1 = tone_start, 2 = tone_error, 3 = both (never legal)
    always @(negedge clk) begin
        note_t e;
        int    kind;
        if (busy === 1'b1) busy_cnt++;
        if (tone_start === 1'b1 || tone_error === 1'b1) begin
            kind = (tone_start === 1'b1 ? 1 : 0) + (tone_error === 1'b1 ? 2 : 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("note_cycle", cyc, e.cyc);
                check("note_kind", kind, e.kind);
                check("note_item", int'(tone_item), e.item);
            end
        end
        if (g_tone_start === 1'b1) gap0_q.push_back(cyc);
    end

    task automatic pulse(input logic c, input logic v, input logic e,
                         input logic [1:0] item, output int k);
        @(negedge clk);
        coin_req  = c;
        vend_req  = v;
        error_req = e;
        vend_item = item;
        @(posedge clk);
        #1;
        k         = cyc;
        coin_req  = 1'b0;
        vend_req  = 1'b0;
        error_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(n < 300), 1);
        repeat (4) @(negedge clk);
        check({tag, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        int k, k2, ke;
        rst = 1'b0;
        {coin_req, vend_req, error_req, vend_item} = '0;
        {g_coin_req, g_vend_req, g_error_req, g_vend_item} = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tone_start", int'(tone_start), 0);
        check("rst_tone_error", int'(tone_error), 0);
        check("rst_tone_item", int'(tone_item), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // vend item 2: notes at k+1 (item 2), k+7 (item 3), busy 12 cycles
        busy_cnt = 0;
        pulse(1'b0, 1'b1, 1'b0, 2'd2, k);
        expect_note(k + 1, 1, 2);
        expect_note(k + 7, 1, 3);
        wait_idle("vend_drain");
        check("vend_busy_cycles", busy_cnt, 12);

        // simultaneous requests: error, then vend, then coin
        pulse(1'b1, 1'b1, 1'b1, 2'd1, k);
        expect_note(k + 1, 2, 0);
        expect_note(k + 7, 2, 0);
        expect_note(k + 14, 1, 1);
        expect_note(k + 20, 1, 3);
        expect_note(k + 27, 1, 0);
        wait_idle("prio_drain");

        // error preempts vend three cycles in; vend note 2 never plays
        pulse(1'b0, 1'b1, 1'b0, 2'd2, k);
        expect_note(k + 1, 1, 2);
        repeat (3) @(posedge clk);
        pulse(1'b0, 1'b0, 1'b1, 2'd0, ke);
        check("preempt_edge", ke, k + 4);
        expect_note(ke, 2, 0);
        expect_note(ke + 6, 2, 0);
        wait_idle("preempt_drain");

        // two vend requests before grant collapse into one using the last item
        pulse(1'b1, 1'b0, 1'b0, 2'd0, k);
        expect_note(k + 1, 1, 0);
        expect_note(k + 8, 1, 0);
        expect_note(k + 14, 1, 3);
        pulse(1'b0, 1'b1, 1'b0, 2'd1, k2);
        pulse(1'b0, 1'b1, 1'b0, 2'd0, k2);
        wait_idle("lastwins_drain");

        // reset mid-coin note drops the pattern
        pulse(1'b1, 1'b0, 1'b0, 2'd0, k);
        expect_note(k + 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tone_start", int'(tone_start), 0);
        check("midrst_tone_error", int'(tone_error), 0);
        check("midrst_tone_item", int'(tone_item), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("midrst_queue", exp_q.size(), 0);
        pulse(1'b1, 1'b0, 1'b0, 2'd0, k2);
        expect_note(k2 + 1, 1, 0);
        wait_idle("postrst_drain");

        // zero-gap build: vend notes exactly four cycles apart
        @(negedge clk);
        g_vend_req  = 1'b1;
        g_vend_item = 2'd1;
        @(posedge clk);
        #1;
        k          = cyc;
        g_vend_req = 1'b0;
        repeat (30) @(negedge clk);
        check("gap0_count", gap0_q.size(), 2);
        if (gap0_q.size() == 2) begin
            check("gap0_first", gap0_q[0], k + 1);
            check("gap0_spacing", gap0_q[1] - gap0_q[0], 4);
        end
        check("gap0_idle", int'(g_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 100_000_000: system clock frequency.
REQ-002 SHALL have parameter TONE_MS, default 150: note slot length in ms, must be >= 1.
REQ-003 SHALL have parameter GAP_MS, default 50: silent gap after each note in ms, may be 0.
REQ-004 SHALL have parameter ERROR_REPEAT, default 2: number of notes in an error pattern, range 1..7.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port coin_req, input, 1: one-cycle pulse requesting a coin-accepted chirp.
REQ-008 SHALL have port vend_req, input, 1: one-cycle pulse requesting a vend chime.
REQ-009 SHALL have port vend_item, input, 2: item index, sampled only when vend_req is high.
REQ-010 SHALL have port error_req, input, 1: one-cycle pulse requesting an error pattern.
REQ-011 SHALL have port tone_start, output, 1: one-cycle pulse that starts a note on the tone generator's vend input.
REQ-012 SHALL have port tone_error, output, 1: one-cycle pulse that starts an error-pitch note on the tone generator's error input.
REQ-013 SHALL have port tone_item, output, 2: pitch select for the tone generator, held stable for the whole note slot.
REQ-014 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-015 SHALL derive NOTE_CYCLES = (CLOCK_HZ/1000)*TONE_MS and GAP_CYCLES = (CLOCK_HZ/1000)*GAP_MS; all counters are 32 bits.
REQ-016 SHALL keep one pending flag per requester; a request pulse sets its flag, and a repeated request while the flag is set is absorbed.
REQ-017 SHALL latch vend_item into a pending-item register on every vend_req; the last request before grant wins.
REQ-018 SHALL have FSM states IDLE, START, PLAY, GAP.
REQ-019 SHALL, in IDLE with any flag set, grant by fixed priority error > vend > coin, clear only the granted flag, load the pattern, and go to START.
REQ-020 SHALL use these patterns:
  - error: ERROR_REPEAT notes, each started by tone_error, with tone_item = 0.
  - vend: note 1 at the latched item, then note 2 at item 3; both started by tone_start.
  - coin: one note at item 0, started by tone_start.
REQ-021 SHALL, in START, pulse exactly one of tone_start or tone_error for one cycle, then go to PLAY.
REQ-022 SHALL span NOTE_CYCLES cycles per note slot, counting the START cycle; PLAY lasts NOTE_CYCLES-1 cycles, and START goes directly to GAP or end-of-note when NOTE_CYCLES = 1.
REQ-023 SHALL, at end of note, enter GAP for GAP_CYCLES cycles; when GAP_CYCLES = 0, GAP is skipped.
REQ-024 SHALL, after GAP, return to START if notes remain, else go to IDLE.
REQ-025 SHALL return from IDLE to IDLE with no idle cycle imposed when a flag is already set; grant happens in the first IDLE cycle.
REQ-026 SHALL, on error_req during a coin or vend pattern, abort that pattern without re-queueing it and enter START of the error pattern on the next edge.
REQ-027 SHALL, on error_req during an error pattern, set the error flag only; the new pattern plays after the current one.
REQ-028 SHALL, when a request arrives in the same cycle its flag is cleared by grant, leave the flag set (set wins over clear).
REQ-029 SHALL have latency from a req sampled high at edge k (IDLE, nothing pending) to the tone pulse sampled high at edge k+2.

Reset
REQ-030 SHALL, while rst is low at an edge, force state IDLE, clear all flags, counters and the pending-item register, and drive tone_start=0, tone_error=0, tone_item=0, busy=0.
REQ-031 SHALL, on reset mid-pattern, drop the pattern and emit no further pulses; the first post-reset request behaves per REQ-029.

Verification (CLOCK_HZ=1000, TONE_MS=4, GAP_MS=2, ERROR_REPEAT=2; 6-cycle note period)
REQ-032 SHALL cover: vend_req with vend_item=2 -> tone_start at k+2 (item 2) and k+8 (item 3); busy high for 12 cycles.
REQ-033 SHALL cover: coin_req, vend_req and error_req in the same cycle -> error pattern (2 tone_error), then vend (2 notes), then coin (1 note), in that order.
REQ-034 SHALL cover: error_req 3 cycles into a vend pattern -> tone_error the next cycle; vend note 2 never issued.
REQ-035 SHALL cover: vend_req with item 1, then vend_req with item 0 before grant -> a single vend pattern whose first note uses item 0.
REQ-036 SHALL cover: rst low for 1 cycle mid-coin note -> all outputs 0 and busy 0; a later coin_req pulses tone_start 2 edges later.
REQ-037 SHALL cover: GAP_MS=0 with the vend pattern -> tone_start pulses exactly 4 cycles apart.
